// File: rtl/karatsuba_mul_acc.sv
// Frame accumulator for Karatsuba multiplier products: sums FRAME_LEN products, then holds the result until it is consumed.
// Define KARATSUBA_ACC_SAT_EN to clamp at the accumulator maximum with a sticky sat_flag; otherwise the sum wraps.
module karatsuba_mul_acc #(
   parameter int n         = 64,
   parameter int ACC_W     = 72,
   parameter int FRAME_LEN = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic [n-1:0]     prod,
   input  logic             prod_valid,
   output logic             prod_ready,
   output logic [ACC_W-1:0] acc_out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       frame_cnt,
   output logic             sat_flag
);

   typedef enum logic {ACC, HOLD} state_t;

   state_t           state;
   logic [ACC_W-1:0] acc;
   logic [7:0]       cnt;
   logic             rdy;
   logic             vld;
   logic [ACC_W-1:0] prod_ext;
   logic             accept;
   logic             last;

`ifdef KARATSUBA_ACC_SAT_EN
   logic             sat;
   logic [ACC_W:0]   sum;

   always_comb begin
      sum = {1'b0, acc} + {1'b0, prod_ext};
   end

   assign sat_flag = sat;
`else
   logic [ACC_W-1:0] sum;

   always_comb begin
      sum = acc + prod_ext;
   end

   assign sat_flag = 1'b0;
`endif

   always_comb begin
      prod_ext         = '0;
      prod_ext[n-1:0]  = prod;
   end

   assign accept = prod_valid && rdy && !clr;
   assign last   = (cnt == 8'(FRAME_LEN - 1));

   // rst and clr share one abort path; rst simply wins by sitting in the same branch.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         state <= ACC;
         acc   <= '0;
         cnt   <= '0;
         rdy   <= 1'b1;
         vld   <= 1'b0;
`ifdef KARATSUBA_ACC_SAT_EN
         sat   <= 1'b0;
`endif
      end else if (state == ACC) begin
         if (accept) begin
`ifdef KARATSUBA_ACC_SAT_EN
            // Once clamped, acc stays at max: any further nonzero product overflows again.
            if (sum[ACC_W]) begin
               acc <= '1;
               sat <= 1'b1;
            end else begin
               acc <= sum[ACC_W-1:0];
            end
`else
            acc <= sum;
`endif
            cnt <= cnt + 8'd1;
            if (last) begin
               state <= HOLD;
               rdy   <= 1'b0;
               vld   <= 1'b1;
            end
         end
      end else begin
         if (out_ready) begin
            state <= ACC;
            acc   <= '0;
            cnt   <= '0;
            rdy   <= 1'b1;
            vld   <= 1'b0;
`ifdef KARATSUBA_ACC_SAT_EN
            sat   <= 1'b0;
`endif
         end
      end
   end

   assign prod_ready = rdy;
   assign out_valid  = vld;
   assign acc_out    = acc;
   assign frame_cnt  = cnt;

endmodule

// File: tb/tb_karatsuba_mul_acc.sv
// Bench for karatsuba_mul_acc: four instances (FRAME_LEN 4/2/1 at ACC_W=72, FRAME_LEN 2 at ACC_W=64) share one stimulus stream.
// An arithmetic frame model is compared every cycle, and literal expectations pin the directed scenarios.
module tb_karatsuba_mul_acc;

   logic        clk = 1'b0;
   logic        rst, clr, prod_valid, out_ready;
   logic [63:0] prod;

   always #5 clk = ~clk;

   logic        r0, v0, s0, r1, v1, s1, r2, v2, s2, r3, v3, s3;
   logic [71:0] a0, a1, a2;
   logic [63:0] a3;
   logic [7:0]  f0, f1, f2, f3;

   karatsuba_mul_acc #(.n(64), .ACC_W(72), .FRAME_LEN(4)) u4 (
      .clk(clk), .rst(rst), .clr(clr), .prod(prod), .prod_valid(prod_valid), .prod_ready(r0),
      .acc_out(a0), .out_valid(v0), .out_ready(out_ready), .frame_cnt(f0), .sat_flag(s0));
   karatsuba_mul_acc #(.n(64), .ACC_W(72), .FRAME_LEN(2)) u2 (
      .clk(clk), .rst(rst), .clr(clr), .prod(prod), .prod_valid(prod_valid), .prod_ready(r1),
      .acc_out(a1), .out_valid(v1), .out_ready(out_ready), .frame_cnt(f1), .sat_flag(s1));
   karatsuba_mul_acc #(.n(64), .ACC_W(72), .FRAME_LEN(1)) u1 (
      .clk(clk), .rst(rst), .clr(clr), .prod(prod), .prod_valid(prod_valid), .prod_ready(r2),
      .acc_out(a2), .out_valid(v2), .out_ready(out_ready), .frame_cnt(f2), .sat_flag(s2));
   karatsuba_mul_acc #(.n(64), .ACC_W(64), .FRAME_LEN(2)) u64 (
      .clk(clk), .rst(rst), .clr(clr), .prod(prod), .prod_valid(prod_valid), .prod_ready(r3),
      .acc_out(a3), .out_valid(v3), .out_ready(out_ready), .frame_cnt(f3), .sat_flag(s3));

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   task automatic cmp(input string nm, input logic [72:0] act, input logic [72:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // Frame model: plain integer sums per instance, ranged by each instance's width and frame length.
   int          fl[4] = '{4, 2, 1, 2};
   int          aw[4] = '{72, 72, 72, 64};
   logic [72:0] m_acc[4];
   int          m_cnt[4];
   bit          m_hold[4];
   bit          m_sat[4];
   logic [72:0] m_sum, m_max;

   initial begin
      for (int i = 0; i < 4; i++) begin
         m_acc[i] = '0; m_cnt[i] = 0; m_hold[i] = 1'b0; m_sat[i] = 1'b0;
      end
   end

   always @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (rst || clr || (m_hold[i] && out_ready)) begin
            m_acc[i] = '0; m_cnt[i] = 0; m_hold[i] = 1'b0; m_sat[i] = 1'b0;
         end else if (!m_hold[i] && prod_valid) begin
            m_max = (73'd1 << aw[i]) - 73'd1;
            m_sum = m_acc[i] + {9'd0, prod};
`ifdef KARATSUBA_ACC_SAT_EN
            if (m_sum > m_max) begin
               m_acc[i] = m_max;
               m_sat[i] = 1'b1;
            end else begin
               m_acc[i] = m_sum;
            end
`else
            m_acc[i] = m_sum & m_max;
`endif
            m_cnt[i] = m_cnt[i] + 1;
            if (m_cnt[i] == fl[i]) m_hold[i] = 1'b1;
         end
      end
   end

   task automatic chk_inst(input int i, input logic r, input logic v, input logic [72:0] a,
                           input logic [7:0] f, input logic s);
      logic exp_sat;
`ifdef KARATSUBA_ACC_SAT_EN
      exp_sat = m_sat[i];
`else
      exp_sat = 1'b0;
`endif
      cmp($sformatf("inst%0d.prod_ready", i), r, !m_hold[i]);
      cmp($sformatf("inst%0d.out_valid", i), v, m_hold[i]);
      cmp($sformatf("inst%0d.acc_out", i), a, m_acc[i]);
      cmp($sformatf("inst%0d.frame_cnt", i), f, 73'(m_cnt[i]));
      cmp($sformatf("inst%0d.sat_flag", i), s, exp_sat);
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk_inst(0, r0, v0, a0, f0, s0);
         chk_inst(1, r1, v1, a1, f1, s1);
         chk_inst(2, r2, v2, a2, f2, s2);
         chk_inst(3, r3, v3, a3, f3, s3);
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_rst;
      rst = 1'b1; clr = 1'b0; prod_valid = 1'b0;
      tick;
      rst = 1'b0;
   endtask

   logic [63:0] s1v[4];
   int          mode;

   initial begin
      rst = 1'b1; clr = 1'b0; prod_valid = 1'b0; prod = '0; out_ready = 1'b0;
      tick;
      chk_en = 1'b1;
      tick;
      cmp("reset.prod_ready", r0, 1'b1);
      cmp("reset.out_valid", v0, 1'b0);
      cmp("reset.acc_out", a0, 0);
      cmp("reset.frame_cnt", f0, 0);
      rst = 1'b0;

      // FRAME_LEN=4 basic frame
      s1v = '{64'd5, 64'd7, 64'd11, 64'd13};
      out_ready = 1'b1; prod_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         prod = s1v[k];
         tick;
         cmp($sformatf("s1.out_valid_c%0d", k + 2), v0, (k == 3));
      end
      cmp("s1.acc_out", a0, 73'd36);
      cmp("s1.frame_cnt", f0, 73'd4);
      prod_valid = 1'b0;
      tick;
      cmp("s1.after_out_valid", v0, 1'b0);
      cmp("s1.after_acc_out", a0, 0);
      cmp("s1.after_prod_ready", r0, 1'b1);
      pulse_rst;

      // FRAME_LEN=2 hold under backpressure
      out_ready = 1'b0; prod_valid = 1'b1; prod = '1;
      tick;
      tick;
      cmp("s2.out_valid", v1, 1'b1);
      cmp("s2.acc_out", a1, 73'h1_FFFF_FFFF_FFFF_FFFE);
      prod = 64'h1234;
      for (int k = 0; k < 3; k++) begin
         tick;
         cmp($sformatf("s2.hold_acc_%0d", k), a1, 73'h1_FFFF_FFFF_FFFF_FFFE);
         cmp($sformatf("s2.hold_ready_%0d", k), r1, 1'b0);
         cmp($sformatf("s2.hold_cnt_%0d", k), f1, 73'd2);
      end
      out_ready = 1'b1;
      tick;
      cmp("s2.release_out_valid", v1, 1'b0);
      cmp("s2.release_acc", a1, 0);
      cmp("s2.release_cnt", f1, 0);
      pulse_rst;

      // ACC_W=64 overflow
      out_ready = 1'b0; prod_valid = 1'b1; prod = 64'hFFFF_FFFF_FFFF_FFF0;
      tick;
      prod = 64'h20;
      tick;
`ifdef KARATSUBA_ACC_SAT_EN
      cmp("s3.acc_out", a3, 73'hFFFF_FFFF_FFFF_FFFF);
      cmp("s3.sat_flag", s3, 1'b1);
`else
      cmp("s3.acc_out", a3, 73'h10);
      cmp("s3.sat_flag", s3, 1'b0);
`endif
      prod_valid = 1'b0; out_ready = 1'b1;
      tick;
      cmp("s3.release_sat", s3, 1'b0);
      pulse_rst;

      // clr with coincident product
      out_ready = 1'b1; prod_valid = 1'b1; prod = 64'd1;
      tick;
      prod = 64'd2;
      tick;
      cmp("s4.pre_cnt", f0, 73'd2);
      cmp("s4.pre_acc", a0, 73'd3);
      clr = 1'b1; prod = 64'd100;
      tick;
      cmp("s4.clr_acc", a0, 0);
      cmp("s4.clr_cnt", f0, 0);
      clr = 1'b0; prod = 64'd6;
      tick;
      cmp("s4.next_cnt", f0, 73'd1);
      cmp("s4.next_acc", a0, 73'd6);
      pulse_rst;

      // rst while holding a result
      out_ready = 1'b0; prod_valid = 1'b1; prod = 64'd9;
      repeat (4) tick;
      cmp("s5.hold_out_valid", v0, 1'b1);
      cmp("s5.hold_acc", a0, 73'd36);
      rst = 1'b1; prod_valid = 1'b0;
      tick;
      cmp("s5.rst_out_valid", v0, 1'b0);
      cmp("s5.rst_prod_ready", r0, 1'b1);
      cmp("s5.rst_acc", a0, 0);
      rst = 1'b0; out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick;
         cmp($sformatf("s5.no_pulse_%0d", k), v0, 1'b0);
      end

      // FRAME_LEN=1 back-to-back
      out_ready = 1'b1; prod_valid = 1'b1; prod = 64'd3;
      cmp("s6.ready_0", r2, 1'b1);
      tick;
      cmp("s6.ready_1", r2, 1'b0);
      cmp("s6.result_a", a2, 73'd3);
      cmp("s6.valid_a", v2, 1'b1);
      prod = 64'd9;
      tick;
      cmp("s6.ready_2", r2, 1'b1);
      tick;
      cmp("s6.ready_3", r2, 1'b0);
      cmp("s6.result_b", a2, 73'd9);
      cmp("s6.valid_b", v2, 1'b1);
      prod_valid = 1'b0;
      tick;
      pulse_rst;

      // Random traffic
      repeat (3000) begin
         rst        = ($urandom_range(0, 99) == 0);
         clr        = ($urandom_range(0, 29) == 0);
         prod_valid = ($urandom_range(0, 3) != 0);
         out_ready  = ($urandom_range(0, 2) != 0);
         mode       = $urandom_range(0, 2);
         if (mode == 0)      prod = 64'($urandom_range(0, 1000));
         else if (mode == 1) prod = {$urandom, $urandom};
         else                prod = 64'hFFFF_FFFF_FFFF_FF00 | 64'($urandom_range(0, 255));
         tick;
      end
      rst = 1'b0; clr = 1'b0; prod_valid = 1'b0;
      tick;
      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/karatsuba_mul_acc.md
KARATSUBA_MUL_ACC -- requirements
Module: karatsuba_mul_acc

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 The block SHALL take these parameters:
- n, default 64: product width, matching the multiplier output C.
- ACC_W, default 72: accumulator width; ACC_W >= n.
- FRAME_LEN, default 16: number of products summed per result; legal range 1..255.
REQ-003 The block SHALL have these ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: synchronous active-high reset.
- clr, input, 1: synchronous frame abort; zeroes the accumulator and count.
- prod, input, n: unsigned product from the multiplier.
- prod_valid, input, 1: prod carries a new product this cycle.
- prod_ready, output, 1: the block accepts a product this cycle.
- acc_out, output, ACC_W: the completed frame sum.
- out_valid, output, 1: acc_out holds a completed result.
- out_ready, input, 1: the consumer accepts acc_out.
- frame_cnt, output, 8: number of products accepted in the current frame.
- sat_flag, output, 1: saturation occurred in the frame now held on acc_out.

Function
REQ-004 The block SHALL implement a two-state FSM: ACC (collecting products) and HOLD (result presented).
REQ-005 In ACC, prod_ready SHALL be 1 and out_valid SHALL be 0.
REQ-006 In HOLD, prod_ready SHALL be 0 and out_valid SHALL be 1.
REQ-007 A product SHALL be accepted only on a cycle where prod_valid && prod_ready && !clr.
REQ-008 On acceptance, the accumulator SHALL become acc + zero_extend(prod), and frame_cnt SHALL increment by 1.
REQ-009 When the accepted product is number FRAME_LEN of the frame, the next cycle SHALL be in HOLD.
- acc_out SHALL equal the full frame sum, including that last product.
- frame_cnt SHALL read FRAME_LEN.
REQ-010 Latency from acceptance of the last product to out_valid=1 SHALL be exactly 1 cycle.
REQ-011 In HOLD, acc_out, sat_flag and frame_cnt SHALL stay stable until out_valid && out_ready.
REQ-012 On out_valid && out_ready, the next cycle SHALL be in ACC with accumulator=0, frame_cnt=0 and sat_flag=0.
- No product is accepted in that handshake cycle.
REQ-013 With FRAME_LEN=1, every accepted product SHALL go straight to HOLD, with acc_out = zero_extend(prod).
REQ-014 clr SHALL have priority over prod_valid and out_ready in both states.
- The next state is ACC, with accumulator=0, frame_cnt=0, sat_flag=0.
- A coincident product is dropped.
REQ-015 prod_valid while prod_ready=0 SHALL have no effect; upstream holds or drops it, and the block keeps no skid buffer.
REQ-016 acc_out SHALL show the live accumulator in ACC and the frozen result in HOLD.
REQ-017 Without saturation (see Configuration), the accumulator SHALL wrap modulo 2^ACC_W.

Reset
REQ-018 On a clk edge with rst=1, the block SHALL go to ACC with accumulator=0, frame_cnt=0, sat_flag=0, out_valid=0 and prod_ready=1.
REQ-019 rst SHALL have priority over clr and all handshakes.
REQ-020 rst asserted mid-frame or in HOLD SHALL discard the partial sum or held result, and no out_valid pulse SHALL follow.
REQ-021 On the first cycle after rst deasserts, the block SHALL be able to accept a product.

Configuration
REQ-022 The macro KARATSUBA_ACC_SAT_EN SHALL control saturation.
- Defined: if acc + prod would exceed 2^ACC_W-1, the accumulator SHALL clamp to 2^ACC_W-1 and stay there for the rest of the frame, and sat_flag SHALL be set sticky until the frame ends (REQ-012 or REQ-014).
- Not defined: the accumulator SHALL wrap per REQ-017, and sat_flag SHALL be tied to 0.
REQ-023 The port list SHALL be identical with and without KARATSUBA_ACC_SAT_EN.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- FRAME_LEN=4, prods 5, 7, 11, 13 on consecutive cycles, out_ready=1 -> out_valid on cycle 5 only, acc_out=36, frame_cnt=4, then back in ACC with acc_out=0.
- FRAME_LEN=2, prods 64'hFFFF_FFFF_FFFF_FFFF twice, out_ready=0 for 3 cycles -> acc_out=72'h1_FFFF_FFFF_FFFF_FFFE held stable and prod_ready=0 for all 3 cycles; result released on out_ready=1.
- ACC_W=64, FRAME_LEN=2, prods 64'hFFFF_FFFF_FFFF_FFF0 and 64'h20 -> with macro: acc_out=64'hFFFF_FFFF_FFFF_FFFF, sat_flag=1; without macro: acc_out=64'h10, sat_flag=0.
- FRAME_LEN=4, 2 products accepted, then clr=1 coincident with prod_valid=1 -> next cycle acc_out=0, frame_cnt=0; the coincident product is not counted.
- rst=1 asserted in HOLD with out_ready=0 -> next cycle out_valid=0, prod_ready=1, acc_out=0; no result ever emitted for that frame.
- FRAME_LEN=1, prod_valid held high with prods 3, 9 and out_ready=1 -> two results, 3 then 9, with prod_ready toggling 1, 0, 1, 0.
